reg_pipe_rst_y_hs: RTL and testbench

Parametrised register pipeline that generalises the single enabled data register. It has configurable data width, configurable depth, async reset to a programmable value, and a valid/ready handshake per stage. Each stage holds a data word plus a valid bit, and bubbles collapse under backpressure. It is the standard retiming/delay element between datapath units that need flow control.

---
 rtl/reg_pipe_rst_y_hs.sv | 94 +++++++++
 tb/tb_reg_pipe_rst_y_hs.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reg_pipe_rst_y_hs.sv
// Valid/ready register pipeline of STAGES entries; latency STAGES cycles, 1 word/cycle throughput.
// Backpressure ripples through a combinational ready chain so bubbles collapse; i_en=0 freezes all state.
module reg_pipe_rst_y_hs #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STAGES     = 3,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_flush,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [$clog2(STAGES+1)-1:0]   o_count
);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0]     r_v;
    logic [DATA_WIDTH-1:0] r_d [STAGES];
    logic [CW-1:0]         r_cnt;

    logic [STAGES:0]       w_rdy;
    logic [STAGES-1:0]     w_load;
    logic [STAGES-1:0]     w_leave;
    logic [STAGES-1:0]     w_v_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_acc;

    // rdy[k] is set when any stage from k to the output is empty, or downstream is taking a word.
    always_comb begin
        w_acc         = i_ready;
        w_rdy[STAGES] = w_acc;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc    = w_acc | ~r_v[k];
            w_rdy[k] = w_acc;
        end
    end

    always_comb begin
        w_load    = '0;
        w_leave   = '0;
        w_v_nxt   = '0;
        w_cnt_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_leave[k] = r_v[k] & w_rdy[k+1] & i_en;
        end
        w_load[0] = i_valid & w_rdy[0] & i_en;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = w_leave[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_v_nxt[k] = w_load[k] | (r_v[k] & ~w_leave[k]);
            w_cnt_nxt  = w_cnt_nxt + CW'(w_v_nxt[k]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_d[k] <= RST_VAL;
            end
        end else if (i_flush) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_d[k] <= RST_VAL;
            end
        end else begin
            r_v   <= w_v_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_load[0]) begin
                r_d[0] <= i_data;
            end
            // Data of a vacated stage is left stale; only its valid bit matters.
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_d[k] <= r_d[k-1];
                end
            end
        end
    end

    assign o_ready = w_rdy[0] & i_en & ~i_flush;
    assign o_valid = r_v[STAGES-1];
    assign o_data  = r_d[STAGES-1];
    assign o_count = r_cnt;

endmodule

// File: tb/tb_reg_pipe_rst_y_hs.sv
// Directed-vector bench for reg_pipe_rst_y_hs with DATA_WIDTH=32, STAGES=3, RST_VAL=0.
module tb_reg_pipe_rst_y_hs;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_count;

    int n_vec = 0;
    int n_err = 0;

    reg_pipe_rst_y_hs #(.DATA_WIDTH(32), .STAGES(3), .RST_VAL(32'h0)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, {31'b0, o_valid}, {31'b0, v});
        if (v) chk({tag, ".data"}, o_data, d);
        chk({tag, ".count"}, {30'b0, o_count}, {30'b0, c});
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
        i_data = '0; i_ready = 1'b1;
        #2;
        chk("rst.valid", {31'b0, o_valid}, 32'd0);
        chk("rst.data", o_data, 32'h0);
        chk("rst.count", {30'b0, o_count}, 32'd0);
        tick();
        i_rst = 1'b0;
        tick();
        chk("rst.ready", {31'b0, o_ready}, 32'd1);

        // 1: stream three words with i_ready=1
        i_valid = 1'b1; i_data = 32'hFFFF0000; tick(); chk_out("t1.e1", 1'b0, 32'h0, 2'd1);
        i_data = 32'hFFFF00FF; tick(); chk_out("t1.e2", 1'b0, 32'h0, 2'd2);
        i_data = 32'hFFFFFFFF; tick(); chk_out("t1.e3", 1'b1, 32'hFFFF0000, 2'd3);
        i_valid = 1'b0;
        tick(); chk_out("t1.e4", 1'b1, 32'hFFFF00FF, 2'd2);
        tick(); chk_out("t1.e5", 1'b1, 32'hFFFFFFFF, 2'd1);
        tick(); chk_out("t1.e6", 1'b0, 32'h0, 2'd0);

        // 2: backpressure, fourth word held upstream then enters on the first pop
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 32'hA1; tick();
        i_data = 32'hA2; tick();
        i_data = 32'hA3; tick(); chk_out("t2.full", 1'b1, 32'hA1, 2'd3);
        i_data = 32'hA4; #1;
        chk("t2.rdy_full", {31'b0, o_ready}, 32'd0);
        tick(); chk_out("t2.hold", 1'b1, 32'hA1, 2'd3);
        i_ready = 1'b1; #1;
        chk("t2.rdy_pass", {31'b0, o_ready}, 32'd1);
        tick(); chk_out("t2.pushpop", 1'b1, 32'hA2, 2'd3);
        i_valid = 1'b0;
        tick(); chk_out("t2.d3", 1'b1, 32'hA3, 2'd2);
        tick(); chk_out("t2.d4", 1'b1, 32'hA4, 2'd1);
        tick(); chk_out("t2.empty", 1'b0, 32'h0, 2'd0);

        // 3: bubble collapse behind a stalled output
        i_valid = 1'b1; i_data = 32'hB0; tick();
        i_valid = 1'b0; tick(); tick();
        chk_out("t3.a_out", 1'b1, 32'hB0, 2'd1);
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hB1; tick();
        chk_out("t3.b_in", 1'b1, 32'hB0, 2'd2);
        i_valid = 1'b0; tick();
        chk_out("t3.b_adv", 1'b1, 32'hB0, 2'd2);
        i_valid = 1'b1; i_data = 32'hB2; #1;
        chk("t3.rdy_collapse", {31'b0, o_ready}, 32'd1);
        tick(); chk_out("t3.full", 1'b1, 32'hB0, 2'd3);
        i_valid = 1'b0; i_ready = 1'b1;
        tick(); chk_out("t3.d1", 1'b1, 32'hB1, 2'd2);
        tick(); chk_out("t3.d2", 1'b1, 32'hB2, 2'd1);
        tick(); chk_out("t3.empty", 1'b0, 32'h0, 2'd0);

        // 4: enable freeze with two words in flight
        i_valid = 1'b1; i_data = 32'hC1; tick();
        i_data = 32'hC2; tick();
        i_valid = 1'b0; tick(); chk_out("t4.pre", 1'b1, 32'hC1, 2'd2);
        i_en = 1'b0; i_valid = 1'b1; i_data = 32'hC3; i_ready = 1'b1; #1;
        chk("t4.rdy", {31'b0, o_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_out("t4.frz", 1'b1, 32'hC1, 2'd2);
        end
        i_en = 1'b1; i_valid = 1'b0;
        tick(); chk_out("t4.d2", 1'b1, 32'hC2, 2'd1);
        tick(); chk_out("t4.empty", 1'b0, 32'h0, 2'd0);

        // 5: flush a full pipeline while a word is offered
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 32'hD1; tick();
        i_data = 32'hD2; tick();
        i_data = 32'hD3; tick(); chk_out("t5.full", 1'b1, 32'hD1, 2'd3);
        i_ready = 1'b1; i_data = 32'hD4; i_flush = 1'b1; #1;
        chk("t5.rdy", {31'b0, o_ready}, 32'd0);
        tick();
        chk_out("t5.flushed", 1'b0, 32'h0, 2'd0);
        chk("t5.data", o_data, 32'h0);
        i_flush = 1'b0; i_valid = 1'b0;
        tick(); chk_out("t5.after", 1'b0, 32'h0, 2'd0);
        // flush still applies while disabled
        i_valid = 1'b1; i_data = 32'hD5; tick();
        i_valid = 1'b0; i_en = 1'b0; i_flush = 1'b1; tick();
        chk_out("t5.flush_dis", 1'b0, 32'h0, 2'd0);
        i_en = 1'b1; i_flush = 1'b0;
        tick(); tick(); tick();
        chk_out("t5.nothing", 1'b0, 32'h0, 2'd0);

        // 6: asynchronous reset mid-stream
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 32'hE1; tick();
        i_data = 32'hE2; tick();
        i_data = 32'hE3; tick(); chk_out("t6.full", 1'b1, 32'hE1, 2'd3);
        i_valid = 1'b0;
        #3 i_rst = 1'b1;
        #1;
        chk("t6.async_valid", {31'b0, o_valid}, 32'd0);
        chk("t6.async_data", o_data, 32'h0);
        chk("t6.async_count", {30'b0, o_count}, 32'd0);
        #2 i_rst = 1'b0;
        i_ready = 1'b1;
        tick(); chk_out("t6.idle", 1'b0, 32'h0, 2'd0);
        i_valid = 1'b1; i_data = 32'hF1; tick(); chk_out("t6.e1", 1'b0, 32'h0, 2'd1);
        i_valid = 1'b0;
        tick(); chk_out("t6.e2", 1'b0, 32'h0, 2'd1);
        tick(); chk_out("t6.e3", 1'b1, 32'hF1, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
